// File: rtl/despliegue_producto.sv
// despliegue_producto: signed Booth product to 8-digit 7-seg display via double-dabble; BLANK_ZEROS_EN blanks leading zeros
module despliegue_producto #(
  parameter int REFRESH_BITS = 17
) (
  input  logic        CLK100MHZ,
  input  logic        reset,
  input  logic [15:0] producto,
  input  logic        valido,
  output logic        ocupado,
  output logic [7:0]  AN,
  output logic [6:0]  SEG,
  output logic        DP
);
  typedef enum logic [1:0] {IDLE, CARGA, CONV, FIN} state_t;
  state_t state;
  logic [15:0] prod_q, mag;
  logic sign_q, disp_sign;
  logic [19:0] bcd, bcd_adj, disp_bcd;
  logic [3:0] iter;
  logic [REFRESH_BITS-1:0] presc;
  logic [2:0] idx;
  logic [31:0] bcd_pad;
  logic [3:0] nib;
  logic [7:0] blank;
  logic [6:0] seg_n;
  function automatic logic [6:0] hex7(input logic [3:0] d);
    case (d)
      4'd0: hex7 = 7'b1000000;
      4'd1: hex7 = 7'b1111001;
      4'd2: hex7 = 7'b0100100;
      4'd3: hex7 = 7'b0110000;
      4'd4: hex7 = 7'b0011001;
      4'd5: hex7 = 7'b0010010;
      4'd6: hex7 = 7'b0000010;
      4'd7: hex7 = 7'b1111000;
      4'd8: hex7 = 7'b0000000;
      4'd9: hex7 = 7'b0010000;
      default: hex7 = 7'h7F;
    endcase
  endfunction
  for (genvar g = 0; g < 5; g++) begin : g_adj
    assign bcd_adj[4*g +: 4] = bcd[4*g +: 4] >= 4'd5 ? bcd[4*g +: 4] + 4'd3 : bcd[4*g +: 4];
  end
  // conversion sequencer: latch, take magnitude, 16 add-3/shift steps, publish
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state     <= IDLE;
      ocupado   <= 1'b0;
      disp_bcd  <= '0;
      disp_sign <= 1'b0;
      iter      <= '0;
      prod_q    <= '0;
      mag       <= '0;
      sign_q    <= 1'b0;
      bcd       <= '0;
    end else begin
      case (state)
        IDLE: if (valido) begin
          prod_q  <= producto;
          ocupado <= 1'b1;
          state   <= CARGA;
        end
        CARGA: begin
          sign_q <= prod_q[15];
          mag    <= prod_q[15] ? 16'd0 - prod_q : prod_q;
          bcd    <= '0;
          iter   <= '0;
          state  <= CONV;
        end
        CONV: begin
          {bcd, mag} <= {bcd_adj[18:0], mag, 1'b0};
          iter       <= iter + 4'd1;
          if (iter == 4'd15) state <= FIN;
        end
        FIN: begin
          disp_bcd  <= bcd;
          disp_sign <= sign_q;
          ocupado   <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bcd_pad = {12'h000, disp_bcd};
  assign nib = bcd_pad[{idx, 2'b00} +: 4];
`ifdef BLANK_ZEROS_EN
  assign blank = {3'b000, disp_bcd[19:16] == 4'd0, disp_bcd[19:12] == 8'd0,
                  disp_bcd[19:8] == 12'd0, disp_bcd[19:4] == 16'd0, 1'b0};
`else
  assign blank = 8'h00;
`endif
  assign seg_n = idx == 3'd5 ? (disp_sign ? 7'b0111111 : 7'h7F) :
                 idx > 3'd5  ? 7'h7F :
                 blank[idx]  ? 7'h7F : hex7(nib);
  // digit scan: prescaler wrap advances the digit, anode/segments registered together
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      presc <= '0;
      idx   <= '0;
      AN    <= 8'hFF;
      SEG   <= 7'h7F;
      DP    <= 1'b1;
    end else begin
      presc <= presc + 1'b1;
      if (&presc) idx <= idx + 3'd1;
      AN    <= ~(8'd1 << idx);
      SEG   <= seg_n;
      DP    <= 1'b1;
    end
  end
endmodule
